// File: rtl/axi_read_arbiter_pkg.sv
// Shared widths, FSM state and master-index types for the two-master AXI read arbiter.
package axi_read_arbiter_pkg;

  localparam int unsigned AXI_ID_BITS    = 4;
  localparam int unsigned AXI_IDS_BITS   = 8;
  localparam int unsigned AXI_ADDR_BITS  = 32;
  localparam int unsigned AXI_LEN_BITS   = 4;
  localparam int unsigned AXI_SIZE_BITS  = 3;
  localparam int unsigned AXI_BURST_BITS = 2;
  localparam int unsigned AXI_DATA_BITS  = 32;
  localparam int unsigned AXI_RESP_BITS  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Master index: 0 = instruction cache, 1 = data cache.
  typedef logic [0:0] mst_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel bundle (AR + R); ID width differs between master and slave sides.
interface axi_read_arbiter_if
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned ID_BITS = AXI_ID_BITS
);

  logic [ID_BITS-1:0]        arid;
  logic [AXI_ADDR_BITS-1:0]  araddr;
  logic [AXI_LEN_BITS-1:0]   arlen;
  logic [AXI_SIZE_BITS-1:0]  arsize;
  logic [AXI_BURST_BITS-1:0] arburst;
  logic                      arvalid;
  logic                      arready;

  logic [ID_BITS-1:0]        rid;
  logic [AXI_DATA_BITS-1:0]  rdata;
  logic [AXI_RESP_BITS-1:0]  rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_read_arbiter_rr_pointer.sv
// Two-requester round-robin pick with registered last_grant, updated when a burst completes.
module axi_read_arbiter_rr_pointer
  import axi_read_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  mst_t       done_idx,
  output mst_t       pick_c,
  output mst_t       last_grant
);

  // Reset to M1 so that M0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= mst_t'(1'b1);
    end else if (done) begin
      last_grant <= done_idx;
    end
  end

  assign pick_c = (req == 2'b11) ? mst_t'(~last_grant) : mst_t'(req[1]);

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter, one burst outstanding, round-robin on ties.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s
);

  localparam int unsigned TAG_BITS = AXI_IDS_BITS - AXI_ID_BITS;

  arb_state_e state;
  mst_t       g;
  mst_t       pick;
  mst_t       last_grant;
  logic       in_addr, in_data;
  logic       addr0, addr1, data0, data1;
  logic       ar_hs, r_done;
  logic       unused_rid_hi;

  axi_read_arbiter_rr_pointer u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        ({m1.arvalid, m0.arvalid}),
    .done       (r_done),
    .done_idx   (g),
    .pick_c     (pick),
    .last_grant (last_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= mst_t'(1'b0);
    end else begin
      case (state)
        IDLE: if (m0.arvalid || m1.arvalid) begin
          g     <= pick;
          state <= ADDR;
        end
        ADDR: if (ar_hs) state <= DATA;
        DATA: if (r_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign addr0   = in_addr && (g == mst_t'(1'b0));
  assign addr1   = in_addr && (g == mst_t'(1'b1));
  assign data0   = in_data && (g == mst_t'(1'b0));
  assign data1   = in_data && (g == mst_t'(1'b1));

  assign ar_hs  = s.arvalid && s.arready;
  assign r_done = s.rvalid && s.rready && s.rlast && in_data;

  // AR path: granted master's request forwarded with its index as the ID tag.
  assign s.arvalid = (addr0 && m0.arvalid) || (addr1 && m1.arvalid);
  assign s.arid    = addr1 ? {TAG_BITS'(g), m1.arid}    : addr0 ? {TAG_BITS'(g), m0.arid} : '0;
  assign s.araddr  = addr1 ? m1.araddr  : addr0 ? m0.araddr  : '0;
  assign s.arlen   = addr1 ? m1.arlen   : addr0 ? m0.arlen   : '0;
  assign s.arsize  = addr1 ? m1.arsize  : addr0 ? m0.arsize  : '0;
  assign s.arburst = addr1 ? m1.arburst : addr0 ? m0.arburst : '0;
  assign m0.arready = addr0 && s.arready;
  assign m1.arready = addr1 && s.arready;

  // R path: purely combinational steering to the granted master.
  assign s.rready  = (data0 && m0.rready) || (data1 && m1.rready);
  assign m0.rvalid = data0 && s.rvalid;
  assign m1.rvalid = data1 && s.rvalid;
  assign m0.rid    = data0 ? s.rid[AXI_ID_BITS-1:0] : '0;
  assign m1.rid    = data1 ? s.rid[AXI_ID_BITS-1:0] : '0;
  assign m0.rdata  = data0 ? s.rdata : '0;
  assign m1.rdata  = data1 ? s.rdata : '0;
  assign m0.rresp  = data0 ? s.rresp : '0;
  assign m1.rresp  = data1 ? s.rresp : '0;
  assign m0.rlast  = data0 && s.rlast;
  assign m1.rlast  = data1 && s.rlast;

  // Upper RID bits carry the master tag, already known from g.
  assign unused_rid_hi = ^{s.rid[AXI_IDS_BITS-1:AXI_ID_BITS], last_grant};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter.
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  axi_read_arbiter_if #(.ID_BITS(AXI_ID_BITS))  m0_if ();
  axi_read_arbiter_if #(.ID_BITS(AXI_ID_BITS))  m1_if ();
  axi_read_arbiter_if #(.ID_BITS(AXI_IDS_BITS)) s_if ();

  axi_read_arbiter dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0;
    m0_if.arburst = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
    m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0;
    m1_if.arburst = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0;
    s_if.rlast = 1'b0; s_if.rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Completes an AR handshake from ADDR, then serves 'beats' beats; returns in IDLE.
  task automatic grant_burst(input int beats, output logic [7:0] arid_seen,
                             output int m0_beats, output int m1_beats);
    m0_beats = 0;
    m1_beats = 0;
    s_if.arready = 1'b1;
    #1;
    arid_seen = s_if.arid;
    step();
    s_if.arready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      s_if.rvalid = 1'b1;
      s_if.rlast  = (i == beats - 1);
      s_if.rdata  = 32'h5000 + 32'(i);
      #1;
      m0_beats += int'(m0_if.rvalid);
      m1_beats += int'(m1_if.rvalid);
      step();
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1; s_if.rvalid = 1'b1; s_if.arready = 1'b1;
    m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    step();
    #1;
    checks++;
    if ({s_if.arvalid, m0_if.arready, m1_if.arready, s_if.rready, m0_if.rvalid, m1_if.rvalid} !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000",
               {s_if.arvalid, m0_if.arready, m1_if.arready, s_if.rready, m0_if.rvalid, m1_if.rvalid});
    else passed++;
    checks++;
    if ({s_if.arid, s_if.araddr, m0_if.rdata} !== 72'h0)
      $display("FAIL reset_payload got=%0h exp=0", {s_if.arid, s_if.araddr, m0_if.rdata});
    else passed++;
    apply_reset();
  endtask

  task automatic test_m0_single();
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_1000; m0_if.arlen = 4'd3;
    m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.arid = 4'h5; m0_if.rready = 1'b1;
    #1;
    checks++;
    if (s_if.arvalid !== 1'b0) $display("FAIL m0_latency got=%b exp=0", s_if.arvalid); else passed++;
    step();
    checks++;
    if (s_if.arvalid !== 1'b1) $display("FAIL m0_arvalid_s got=%b exp=1", s_if.arvalid); else passed++;
    checks++;
    if ({s_if.arid, s_if.araddr, s_if.arlen} !== {8'h05, 32'h0000_1000, 4'd3})
      $display("FAIL m0_ar_payload got=%0h exp=%0h", {s_if.arid, s_if.araddr, s_if.arlen},
               {8'h05, 32'h0000_1000, 4'd3});
    else passed++;
    s_if.arready = 1'b1;
    #1;
    checks++;
    if ({m0_if.arready, m1_if.arready} !== 2'b10)
      $display("FAIL m0_arready got=%b exp=10", {m0_if.arready, m1_if.arready});
    else passed++;
    step();
    s_if.arready = 1'b0;
    m0_if.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.rvalid = 1'b1; s_if.rid = 8'h05; s_if.rdata = 32'hA000 + 32'(i);
      s_if.rlast = (i == 3);
      #1;
      checks++;
      if ({m0_if.rvalid, m0_if.rlast, m0_if.rid, m0_if.rdata, s_if.rready, m1_if.rvalid} !==
          {1'b1, (i == 3), 4'h5, 32'hA000 + 32'(i), 1'b1, 1'b0})
        $display("FAIL m0_beat%0d got=%0h exp=%0h", i,
                 {m0_if.rvalid, m0_if.rlast, m0_if.rid, m0_if.rdata, s_if.rready, m1_if.rvalid},
                 {1'b1, (i == 3), 4'h5, 32'hA000 + 32'(i), 1'b1, 1'b0});
      else passed++;
      step();
    end
    #1;
    checks++;
    if ({m0_if.rvalid, s_if.rready, s_if.arvalid} !== 3'b000)
      $display("FAIL m0_back_to_idle got=%b exp=000", {m0_if.rvalid, s_if.rready, s_if.arvalid});
    else passed++;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] arid_seen;
    int b0, b1;
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.arid = 4'h3; m0_if.araddr = 32'h100; m0_if.rready = 1'b1;
    m1_if.arvalid = 1'b1; m1_if.arid = 4'h9; m1_if.araddr = 32'h200; m1_if.rready = 1'b1;
    step();
    s_if.arready = 1'b1;
    #1;
    checks++;
    if ({m0_if.arready, m1_if.arready} !== 2'b10)
      $display("FAIL tie_arready got=%b exp=10", {m0_if.arready, m1_if.arready});
    else passed++;
    grant_burst(2, arid_seen, b0, b1);
    checks++;
    if ({arid_seen, 8'(b0), 8'(b1)} !== {8'h03, 8'd2, 8'd0})
      $display("FAIL rr_first_m0 got=%0h exp=030200", {arid_seen, 8'(b0), 8'(b1)});
    else passed++;
    checks++;
    if (s_if.arvalid !== 1'b0) $display("FAIL rr_bubble got=%b exp=0", s_if.arvalid); else passed++;
    step();
    checks++;
    if ({s_if.arvalid, s_if.araddr} !== {1'b1, 32'h200})
      $display("FAIL rr_m1_addr got=%0h exp=%0h", {s_if.arvalid, s_if.araddr}, {1'b1, 32'h200});
    else passed++;
    grant_burst(3, arid_seen, b0, b1);
    checks++;
    if ({arid_seen, 8'(b0), 8'(b1)} !== {8'h19, 8'd0, 8'd3})
      $display("FAIL rr_second_m1 got=%0h exp=190003", {arid_seen, 8'(b0), 8'(b1)});
    else passed++;
    step();
    grant_burst(1, arid_seen, b0, b1);
    checks++;
    if ({arid_seen, 8'(b0), 8'(b1)} !== {8'h03, 8'd1, 8'd0})
      $display("FAIL rr_third_m0 got=%0h exp=030100", {arid_seen, 8'(b0), 8'(b1)});
    else passed++;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    apply_reset();
    m1_if.arvalid = 1'b1; m1_if.arid = 4'h7; m1_if.arlen = 4'd3; m1_if.rready = 1'b1;
    step();
    s_if.arready = 1'b1;
    step();
    s_if.arready = 1'b0;
    m1_if.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.rvalid = 1'b1; s_if.rdata = 32'hB0 + 32'(i); s_if.rlast = (i == 3);
      if (i == 1) begin
        m1_if.rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          checks++;
          if ({s_if.rready, m1_if.rvalid, m1_if.rdata} !== {1'b0, 1'b1, 32'hB1})
            $display("FAIL stall%0d got=%0h exp=%0h", k, {s_if.rready, m1_if.rvalid, m1_if.rdata},
                     {1'b0, 1'b1, 32'hB1});
          else passed++;
          step();
        end
        m1_if.rready = 1'b1;
      end
      #1;
      checks++;
      if ({m1_if.rdata, m0_if.rvalid} !== {32'hB0 + 32'(i), 1'b0})
        $display("FAIL bp_beat%0d got=%0h exp=%0h", i, {m1_if.rdata, m0_if.rvalid},
                 {32'hB0 + 32'(i), 1'b0});
      else passed++;
      if (s_if.rvalid && s_if.rready) accepted++;
      step();
    end
    #1;
    checks++;
    if (accepted !== 4) $display("FAIL bp_accepted got=%0d exp=4", accepted); else passed++;
    checks++;
    if ({m1_if.rvalid, s_if.rready} !== 2'b00)
      $display("FAIL bp_idle got=%b exp=00", {m1_if.rvalid, s_if.rready});
    else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_in_data();
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.arid = 4'h2; m0_if.arlen = 4'd3; m0_if.rready = 1'b1;
    step();
    s_if.arready = 1'b1;
    step();
    s_if.arready = 1'b0;
    m0_if.arvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_if.rvalid = 1'b1; s_if.rdata = 32'hC0 + 32'(i);
      step();
    end
    s_if.rdata = 32'hC2;
    #1;
    checks++;
    if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 32'hC2})
      $display("FAIL rst_pre got=%0h exp=%0h", {m0_if.rvalid, m0_if.rdata}, {1'b1, 32'hC2});
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({m0_if.rvalid, s_if.rready, m0_if.rdata} !== 34'h0)
      $display("FAIL rst_async got=%0h exp=0", {m0_if.rvalid, s_if.rready, m0_if.rdata});
    else passed++;
    step();
    rst = 1'b0;
    s_if.rvalid = 1'b0;
    m1_if.arvalid = 1'b1; m1_if.arid = 4'hE; m1_if.araddr = 32'h3000;
    step();
    checks++;
    if ({s_if.arvalid, s_if.arid, s_if.araddr} !== {1'b1, 8'h1E, 32'h3000})
      $display("FAIL rst_regrant got=%0h exp=%0h", {s_if.arvalid, s_if.arid, s_if.araddr},
               {1'b1, 8'h1E, 32'h3000});
    else passed++;
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_m0_single();
    test_back_to_back();
    test_backpressure();
    test_reset_in_data();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
